// File: rtl/disp_load_ctrl.sv
// Display load controller: arbitrates two digit-word requesters and a clear
// request, then writes 8 digits to the display register file one per cycle.
module disp_load_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        clr_req,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        write,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } st_t;

  st_t         state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] data, data_n;
  logic        pend_q, pend_n;
  logic        last, last_n;
  logic        enter_clr;
  logic        pend;
  logic        g0, g1;
  logic        hs0, hs1;

  logic [3:0]  num_d;
  logic [2:0]  sel_d;
  logic        write_d, busy_d, done_d;

  // A clear pulse seen this cycle already counts as pending.
  assign pend = pend_q | clr_req;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state == IDLE && !reset && !pend) begin
      if (req0_valid && req1_valid) begin
        g0 = last;
        g1 = !last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign hs0 = g0 & req0_valid;
  assign hs1 = g1 & req1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      data   <= 32'd0;
      pend_q <= 1'b0;
      last   <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      data   <= data_n;
      pend_q <= pend_n;
      last   <= last_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    data_n    = data;
    last_n    = last;
    enter_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend) begin
          state_n   = CLEAR;
          cnt_n     = 3'd0;
          enter_clr = 1'b1;
        end else if (hs0) begin
          state_n = LOAD;
          cnt_n   = 3'd0;
          data_n  = req0_data;
          last_n  = 1'b0;
        end else if (hs1) begin
          state_n = LOAD;
          cnt_n   = 3'd0;
          data_n  = req1_data;
          last_n  = 1'b1;
        end
      end
      LOAD, CLEAR: begin
        if (cnt == 3'd7) begin
          cnt_n = 3'd0;
          // A clear queued behind a sequence starts without an idle gap.
          if (pend) begin
            state_n   = CLEAR;
            enter_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
    pend_n = enter_clr ? 1'b0 : pend;
  end

  always_comb begin
    num_d   = num;
    sel_d   = sel;
    write_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (state_n != IDLE) begin
      write_d = 1'b1;
      busy_d  = 1'b1;
      sel_d   = cnt_n;
      done_d  = (cnt_n == 3'd7);
      num_d   = (state_n == LOAD) ? data_n[{cnt_n, 2'b00} +: 4] : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num   <= 4'd0;
      sel   <= 3'd0;
      write <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      num   <= num_d;
      sel   <= sel_d;
      write <= write_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule
